// File: rtl/issue_arbiter.sv
// Two-queue round-robin issue arbiter feeding a single registered output
// stage to a functional unit, with PRF read-port decode and grant counters.
module issue_arbiter #(
  parameter int DATA_WIDTH = 248,
  parameter int PREG_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  fu_valid,
  input  logic                  fu_ready,
  output logic [DATA_WIDTH-1:0] fu_data,
  output logic                  fu_src_id,
  output logic                  prf_rs1_rden,
  output logic                  prf_rs2_rden,
  output logic [PREG_WIDTH-1:0] prf_rs1_rdaddr,
  output logic [PREG_WIDTH-1:0] prf_rs2_rdaddr,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
);

  // Payload field positions of the source-operand descriptors.
  localparam int RS1_LSB    = 111;
  localparam int RS2_LSB    = 105;
  localparam int RS1_EN_BIT = 104;
  localparam int RS2_EN_BIT = 103;

  logic                  rr_ptr_q, rr_ptr_d;
  logic                  fu_valid_q, fu_valid_d;
  logic [DATA_WIDTH-1:0] fu_data_q, fu_data_d;
  logic                  fu_src_id_q, fu_src_id_d;
  logic [15:0]           grant_cnt0_q, grant_cnt0_d;
  logic [15:0]           grant_cnt1_q, grant_cnt1_d;

  logic load;
  logic can_grant;
  logic grant0;
  logic grant1;

  // NOTE: every signal assigned here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    load      = ~fu_valid_q | fu_ready;
    can_grant = load & ~flush;
    grant0    = can_grant & req0_valid & (~req1_valid | ~rr_ptr_q);
    grant1    = can_grant & req1_valid & (~req0_valid |  rr_ptr_q);

    rr_ptr_d     = rr_ptr_q;
    fu_valid_d   = fu_valid_q;
    fu_data_d    = fu_data_q;
    fu_src_id_d  = fu_src_id_q;
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;

    if (grant0 | grant1) begin
      // Only the granted queue's payload is captured, so X on an idle
      // queue's data bus cannot propagate into the output stage.
      fu_valid_d  = 1'b1;
      fu_src_id_d = grant1;
      fu_data_d   = grant1 ? req1_data : req0_data;
      rr_ptr_d    = ~grant1;
    end else if (flush | load) begin
      fu_valid_d = 1'b0;
    end

    if (grant0 && grant_cnt0_q != 16'hFFFF) grant_cnt0_d = grant_cnt0_q + 16'd1;
    if (grant1 && grant_cnt1_q != 16'hFFFF) grant_cnt1_d = grant_cnt1_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  // NOTE: the wide payload register is reset too, so fu_data reads zero
  // after reset rather than stale contents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= 1'b0;
      fu_valid_q   <= 1'b0;
      fu_data_q    <= '0;
      fu_src_id_q  <= 1'b0;
      grant_cnt0_q <= 16'd0;
      grant_cnt1_q <= 16'd0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      fu_valid_q   <= fu_valid_d;
      fu_data_q    <= fu_data_d;
      fu_src_id_q  <= fu_src_id_d;
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  // Grants are combinational, so they are masked while reset is held.
  assign req0_ready     = grant0 & reset_n;
  assign req1_ready     = grant1 & reset_n;
  assign fu_valid       = fu_valid_q;
  assign fu_data        = fu_data_q;
  assign fu_src_id      = fu_src_id_q;
  assign prf_rs1_rdaddr = fu_data_q[RS1_LSB +: PREG_WIDTH];
  assign prf_rs2_rdaddr = fu_data_q[RS2_LSB +: PREG_WIDTH];
  assign prf_rs1_rden   = fu_valid_q & fu_data_q[RS1_EN_BIT];
  assign prf_rs2_rden   = fu_valid_q & fu_data_q[RS2_EN_BIT];
  assign grant_cnt0     = grant_cnt0_q;
  assign grant_cnt1     = grant_cnt1_q;

endmodule

// File: tb/tb_issue_arbiter.sv
// Randomized self-checking bench for issue_arbiter against a transaction-level
// model of the arbitration, output-stage and counter rules.
module tb_issue_arbiter;

  localparam int DW = 248;
  localparam int PW = 6;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          fu_valid, fu_ready, fu_src_id;
  logic [DW-1:0] fu_data;
  logic          prf_rs1_rden, prf_rs2_rden;
  logic [PW-1:0] prf_rs1_rdaddr, prf_rs2_rdaddr;
  logic [15:0]   grant_cnt0, grant_cnt1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_rr;
  bit            m_fv;
  logic [DW-1:0] m_fd;
  int            m_fs;
  int            m_cnt0, m_cnt1;

  issue_arbiter #(.DATA_WIDTH(DW), .PREG_WIDTH(PW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_data(fu_data),
    .fu_src_id(fu_src_id),
    .prf_rs1_rden(prf_rs1_rden), .prf_rs2_rden(prf_rs2_rden),
    .prf_rs1_rdaddr(prf_rs1_rdaddr), .prf_rs2_rdaddr(prf_rs2_rdaddr),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i += 32) r[i +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_fv = 0; m_fd = '0; m_fs = 0; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // Which queue should win this cycle: -1 none, else 0/1.
  function automatic int expected_grant();
    bit can;
    can = (!m_fv || fu_ready) && !flush;
    if (!can) return -1;
    if (req0_valid && req1_valid) return m_rr;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // One clock cycle: drive, check grants, clock, advance model, check state.
  task automatic step(input bit v0, input bit v1, input bit fr, input bit fl,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int g;
    req0_valid = v0; req1_valid = v1; fu_ready = fr; flush = fl;
    req0_data  = v0 ? d0 : 'x;
    req1_data  = v1 ? d1 : 'x;
    #1;
    g = expected_grant();
    total++;
    if (req0_ready !== (g == 0)) begin
      bad++; $display("FAIL req0_ready got=%b exp=%b", req0_ready, g == 0);
    end
    total++;
    if (req1_ready !== (g == 1)) begin
      bad++; $display("FAIL req1_ready got=%b exp=%b", req1_ready, g == 1);
    end
    @(posedge clock);
    if (g >= 0) begin
      m_fv = 1; m_fd = (g == 1) ? d1 : d0; m_fs = g; m_rr = 1 - g;
      if (g == 0 && m_cnt0 < 65535) m_cnt0++;
      if (g == 1 && m_cnt1 < 65535) m_cnt1++;
    end else if (fl || !m_fv || fr) begin
      m_fv = 0;
    end
    #1;
    total++;
    if (fu_valid !== m_fv) begin
      bad++; $display("FAIL fu_valid got=%b exp=%b", fu_valid, m_fv);
    end
    total++;
    if (fu_data !== m_fd) begin
      bad++; $display("FAIL fu_data got=%h exp=%h", fu_data, m_fd);
    end
    total++;
    if (fu_src_id !== m_fs[0]) begin
      bad++; $display("FAIL fu_src_id got=%b exp=%0d", fu_src_id, m_fs);
    end
    total++;
    if (grant_cnt0 !== m_cnt0[15:0] || grant_cnt1 !== m_cnt1[15:0]) begin
      bad++; $display("FAIL grant_cnt got=%0d/%0d exp=%0d/%0d",
                      grant_cnt0, grant_cnt1, m_cnt0, m_cnt1);
    end
    total++;
    if (prf_rs1_rden !== (m_fv & m_fd[104]) || prf_rs2_rden !== (m_fv & m_fd[103]) ||
        prf_rs1_rdaddr !== m_fd[116:111] || prf_rs2_rdaddr !== m_fd[110:105]) begin
      bad++; $display("FAIL prf got=%b%b %0d %0d exp=%b%b %0d %0d",
                      prf_rs1_rden, prf_rs2_rden, prf_rs1_rdaddr, prf_rs2_rdaddr,
                      m_fv & m_fd[104], m_fv & m_fd[103], m_fd[116:111], m_fd[110:105]);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if (fu_valid !== 1'b0 || fu_data !== '0 || fu_src_id !== 1'b0 ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
        prf_rs1_rden !== 1'b0 || prf_rs2_rden !== 1'b0 ||
        grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      bad++;
      $display("FAIL %s got fv=%b src=%b rdy=%b%b rden=%b%b cnt=%0d/%0d data_nz=%b exp all zero",
               name, fu_valid, fu_src_id, req0_ready, req1_ready,
               prf_rs1_rden, prf_rs2_rden, grant_cnt0, grant_cnt1, |fu_data);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_outputs");
    model_reset();
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    flush = 0; fu_ready = 1; req0_valid = 1; req1_valid = 1;
    req0_data = rand_data(); req1_data = rand_data();
    apply_reset();
  endtask

  task automatic test_alternate();
    int seq [4];
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0, rand_data(), rand_data());
      seq[i] = fu_src_id;
    end
    total++;
    if (seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 0 || seq[3] !== 1) begin
      bad++; $display("FAIL alt_src_seq got=%0d%0d%0d%0d exp=0101",
                      seq[0], seq[1], seq[2], seq[3]);
    end
    total++;
    if (grant_cnt0 !== 16'd2 || grant_cnt1 !== 16'd2) begin
      bad++; $display("FAIL alt_counts got=%0d/%0d exp=2/2", grant_cnt0, grant_cnt1);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] first;
    first = rand_data();
    step(1, 0, 1, 0, first, '0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, rand_data(), '0);
      total++;
      if (fu_data !== first) begin
        bad++; $display("FAIL stall_hold got=%h exp=%h", fu_data, first);
      end
    end
    step(1, 0, 1, 0, rand_data(), '0);
  endtask

  task automatic test_prf();
    logic [DW-1:0] d;
    d = rand_data();
    d[116:111] = 6'd5; d[110:105] = 6'd9; d[104] = 1'b1; d[103] = 1'b0;
    step(1, 0, 1, 0, d, '0);
    total++;
    if (prf_rs1_rden !== 1'b1 || prf_rs1_rdaddr !== 6'd5 ||
        prf_rs2_rden !== 1'b0 || prf_rs2_rdaddr !== 6'd9) begin
      bad++; $display("FAIL prf_decode got=%b,%0d %b,%0d exp=1,5 0,9",
                      prf_rs1_rden, prf_rs1_rdaddr, prf_rs2_rden, prf_rs2_rdaddr);
    end
  endtask

  task automatic test_flush();
    int rr_before;
    step(1, 1, 1, 0, rand_data(), rand_data());
    rr_before = m_rr;
    step(1, 1, 1, 1, rand_data(), rand_data());
    step(1, 1, 0, 0, rand_data(), rand_data());
    total++;
    if (fu_src_id !== rr_before[0]) begin
      bad++; $display("FAIL flush_rr got=%b exp=%0d", fu_src_id, rr_before);
    end
    step(1, 1, 0, 1, rand_data(), rand_data());
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, rand_data(), rand_data());
  endtask

  task automatic test_saturate();
    int guard;
    guard = 0;
    while (m_cnt0 < 65534 && guard < 70000) begin
      step(1, 0, 1, 0, rand_data(), '0);
      guard++;
    end
    for (int i = 0; i < 2; i++) step(1, 0, 1, 0, rand_data(), '0);
    total++;
    if (grant_cnt0 !== 16'hFFFF) begin
      bad++; $display("FAIL sat_reach got=%h exp=ffff", grant_cnt0);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, rand_data(), rand_data());
    total++;
    if (grant_cnt0 !== 16'hFFFF) begin
      bad++; $display("FAIL sat_hold got=%h exp=ffff", grant_cnt0);
    end
  endtask

  task automatic test_reset_stall();
    step(1, 1, 1, 0, rand_data(), rand_data());
    step(1, 1, 0, 0, rand_data(), rand_data());
    step(1, 1, 0, 0, rand_data(), rand_data());
    req0_valid = 1; req1_valid = 1; fu_ready = 0;
    apply_reset();
    step(1, 1, 1, 0, rand_data(), rand_data());
    total++;
    if (fu_src_id !== 1'b0 || fu_valid !== 1'b1) begin
      bad++; $display("FAIL post_reset_first got src=%b fv=%b exp src=0 fv=1",
                      fu_src_id, fu_valid);
    end
  endtask

  initial begin
    reset_n = 1'b1; flush = 0; fu_ready = 0;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    model_reset();
    #2;
    test_reset();
    test_alternate();
    test_stall();
    test_prf();
    test_flush();
    test_random();
    test_saturate();
    test_reset_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
